ifu_axi4lite_read_master: RTL
=============================

// Module: ifu_axi4lite_read_master
// PURPOSE
//  AXI4-Lite read-channel initiator (AR + R) for the IFU. Accepts one fetch address from the core,
//  drives AR, collects R and returns the instruction word plus response code to the core.
//  Single outstanding transaction. Supports a redirect flush and a stall watchdog.
//  Sits between the IFU PC logic and the instruction-memory AXI4-Lite responder.
// PARAMETERS
//  ADDR_W   64   address width (= `DATA_WIDTH)
//  INST_W   32   instruction/data width (= `INST_WIDTH)
//  WDOG_MAX 255  cycles in AR/R without handshake before oWdogErr sets; must be >= 1
// PORTS
//  iClock                     in  1      clock, all state updates on rising edge
//  iReset                     in  1      synchronous, active-low reset (0 = reset)
//  iFetchValid                in  1      core requests a fetch
//  iFetchAddr                 in  ADDR_W fetch address, sampled when iFetchValid && oFetchReady
//  oFetchReady                out 1      block can accept a request (IDLE only)
//  iFlush                     in  1      redirect: discard the in-flight fetch result
//  oInstValid                 out 1      instruction result valid
//  oInstData                  out INST_W captured rdata
//  oInstResp                  out 2      captured rresp
//  iInstReady                 in  1      core consumes result
//  oWdogErr                   out 1      sticky: watchdog expired; cleared only by reset
//  bIFUAXIMasterARIO_arvalid  out 1      AR valid
//  bIFUAXIMasterARIO_araddr   out ADDR_W AR address
//  bIFUAXIMasterARIO_arready  in  1      AR ready
//  bIFUAXIMasterRIO_rready    out 1      R ready
//  bIFUAXIMasterRIO_rvalid    in  1      R valid
//  bIFUAXIMasterRIO_rdata     in  INST_W R data
//  bIFUAXIMasterRIO_rresp     in  2      R response (OKAY=0, SLVERR=2, DECERR=3)
// BEHAVIOUR
//  Reset (iReset=0 at edge): state=IDLE; arvalid=0, araddr=0, rready=0, oInstValid=0, oInstData=0,
//   oInstResp=OKAY, oWdogErr=0, drop flag=0, watchdog=0. Applies mid-transaction; AXI side abandoned.
//  FSM: IDLE, AR, R, RESP. Outputs are registered/state-decoded; no combinational input->output paths
//   except oFetchReady = (state==IDLE).
//  IDLE: iFetchValid -> latch araddr, -> AR. arvalid=1 from the next cycle (1-cycle issue latency).
//  AR: arvalid=1, araddr stable; rready=1 (responder may return R in the AR handshake cycle).
//   arready&&rvalid same cycle -> capture R, -> RESP (or IDLE if dropping). arready only -> R.
//  R: arvalid=0, rready=1; rvalid -> capture rdata/rresp, -> RESP (or IDLE if dropping).
//  RESP: oInstValid=1, data/resp held stable until iInstReady; iInstReady -> IDLE, oInstValid=0 next cycle.
//   Best-case request-to-oInstValid: 2 cycles (accept, AR+R handshake, RESP visible).
//  Flush: iFlush in AR or R sets drop flag; the AXI transaction still completes (arvalid never withdrawn
//   before arready); captured beat discarded, -> IDLE, drop flag cleared. iFlush in RESP: oInstValid
//   drops next cycle, -> IDLE. iFlush in IDLE: ignored; a same-cycle iFetchValid is still accepted.
//  rresp is passed through unmodified; no retry. Only rresp[1:0] captured; no width conversion.
//  Watchdog: counts cycles in AR/R, resets on each state entry, saturates at WDOG_MAX; on reaching
//   WDOG_MAX sets oWdogErr. FSM keeps waiting (protocol stays legal).
// STRUCTURE
//  Config.v: `AXI4_RRESP_OKEY/SLVEER/DECERR constants, FSM state encodings (2-bit localparams).
//  Sub-module: axi4lite_wdog (saturating counter, clear/enable inputs, expire output).
// TESTING
//  Zero-wait responder (arready=1, rvalid same cycle as AR, rdata=0x00000413): fetch 0x80000000 ->
//   arvalid cycle 1, oInstValid cycle 2 with data 0x00000413, resp 0.
//  arready delayed 3 cycles, rvalid 2 cycles after: araddr stable 0x80000004 throughout, arvalid high
//   until handshake, single capture, one oInstValid pulse held until iInstReady.
//  iInstReady low 5 cycles: oInstData/oInstResp stable, oFetchReady=0, no new arvalid.
//  iFlush in R state, rdata=0xDEADBEEF: no oInstValid, returns IDLE after rvalid, next fetch normal.
//  rresp=2, rdata=0: oInstResp=2, oInstData=0 delivered. iReset=0 in AR: all outputs reset next edge.
//  WDOG_MAX=4, arready never asserted: oWdogErr=1 after 4 cycles in AR, arvalid still 1, sticky.

Source files
------------

// File: rtl/ifu_axi4lite_read_master_pkg.sv
// Shared types and constants for the IFU AXI4-Lite read initiator:
// FSM state encoding, AXI read response codes and a small state-class helper.
package ifu_axi4lite_read_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] AXI4_RRESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4_RRESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4_RRESP_DECERR = 2'b11;

    // True for the states in which the block is waiting on the responder.
    function automatic logic is_wait_state(input state_e s);
        return (s == ST_AR) || (s == ST_R);
    endfunction

endpackage

// File: rtl/ifu_axi4lite_read_master_if.sv
// AXI4-Lite read address (AR) and read data (R) channel bundle,
// with initiator (master) and responder (slave) views.
interface ifu_axi4lite_read_master_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              arready;
    logic              rready;
    logic              rvalid;
    logic [INST_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/ifu_axi4lite_read_master_wdog.sv
// Saturating stall counter: clears on request, counts while enabled, and
// pulses expire on the cycle whose update brings the count to MAX.
module ifu_axi4lite_read_master_wdog #(
    parameter int MAX = 255
) (
    input  logic iClock,
    input  logic iReset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count and expiry strobe.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en && (cnt_q != CNT_W'(MAX))) begin
            cnt_d  = cnt_q + CNT_W'(1);
            expire = (cnt_d == CNT_W'(MAX));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ifu_axi4lite_read_master.sv
// IFU AXI4-Lite read initiator: one outstanding AR/R transaction per fetch,
// redirect flush that lets the bus transaction finish, and a sticky stall watchdog.
module ifu_axi4lite_read_master
    import ifu_axi4lite_read_master_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int INST_W   = 32,
    parameter int WDOG_MAX = 255
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iFetchValid,
    input  logic [ADDR_W-1:0] iFetchAddr,
    output logic              oFetchReady,
    input  logic              iFlush,
    output logic              oInstValid,
    output logic [INST_W-1:0] oInstData,
    output logic [1:0]        oInstResp,
    input  logic              iInstReady,
    output logic              oWdogErr,
    ifu_axi4lite_read_master_if.master bIFUAXIMasterIO
);
    state_e            state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              rready_q, rready_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_data_q, inst_data_d;
    logic [1:0]        inst_resp_q, inst_resp_d;
    logic              drop_q, drop_d;
    logic              wdog_err_q, wdog_err_d;
    logic              drop_now_s;
    logic              wdog_clr_s;
    logic              wdog_en_s;
    logic              wdog_expire_s;

    // A flush arriving in the same cycle as the R beat still discards that beat.
    assign drop_now_s = drop_q | iFlush;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_resp_d  = inst_resp_q;
        drop_d       = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (iFetchValid) begin
                    state_d   = ST_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = iFetchAddr;
                    rready_d  = 1'b1;
                    drop_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_AR: begin
                drop_d = drop_now_s;
                if (bIFUAXIMasterIO.arready && bIFUAXIMasterIO.rvalid) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    drop_d    = 1'b0;
                    if (drop_now_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_RESP;
                        inst_valid_d = 1'b1;
                        inst_data_d  = bIFUAXIMasterIO.rdata;
                        inst_resp_d  = bIFUAXIMasterIO.rresp;
                    end
                end else if (bIFUAXIMasterIO.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_R;
                end else begin
                    state_d = ST_AR;
                end
            end
            ST_R: begin
                drop_d = drop_now_s;
                if (bIFUAXIMasterIO.rvalid) begin
                    rready_d = 1'b0;
                    drop_d   = 1'b0;
                    if (drop_now_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d      = ST_RESP;
                        inst_valid_d = 1'b1;
                        inst_data_d  = bIFUAXIMasterIO.rdata;
                        inst_resp_d  = bIFUAXIMasterIO.rresp;
                    end
                end else begin
                    state_d = ST_R;
                end
            end
            ST_RESP: begin
                if (iInstReady || iFlush) begin
                    state_d      = ST_IDLE;
                    inst_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                arvalid_d    = 1'b0;
                rready_d     = 1'b0;
                inst_valid_d = 1'b0;
                drop_d       = 1'b0;
            end
        endcase
    end

    // The watchdog restarts on every state change and only counts while waiting on the bus.
    assign wdog_clr_s = (state_d != state_q);
    assign wdog_en_s  = is_wait_state(state_q);
    assign wdog_err_d = wdog_err_q | wdog_expire_s;

    ifu_axi4lite_read_master_wdog #(
        .MAX (WDOG_MAX)
    ) u_wdog (
        .iClock (iClock),
        .iReset (iReset),
        .clr    (wdog_clr_s),
        .en     (wdog_en_s),
        .expire (wdog_expire_s)
    );

    // FSM state and registered outputs with synchronous active-low reset.
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= {ADDR_W{1'b0}};
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= {INST_W{1'b0}};
            inst_resp_q  <= AXI4_RRESP_OKAY;
            drop_q       <= 1'b0;
            wdog_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_resp_q  <= inst_resp_d;
            drop_q       <= drop_d;
            wdog_err_q   <= wdog_err_d;
        end
    end

    assign oFetchReady             = (state_q == ST_IDLE);
    assign oInstValid              = inst_valid_q;
    assign oInstData               = inst_data_q;
    assign oInstResp               = inst_resp_q;
    assign oWdogErr                = wdog_err_q;
    assign bIFUAXIMasterIO.arvalid = arvalid_q;
    assign bIFUAXIMasterIO.araddr  = araddr_q;
    assign bIFUAXIMasterIO.rready  = rready_q;
endmodule
